oam_dma_controller: RTL and testbench
=====================================

Name: oam_dma_controller

Overview:
- Sequences the NES sprite DMA ($4014): on a CPU write of page P, halts the CPU, takes ownership of the CPU memory read/write port and copies $P00–$PFF into PPU OAM.
- Sits between the 6502 core and cpu_memory as a 2:1 bus mux, with a write port toward the PPU OAM.
- The cpu_memory read port returns data in the same cycle (negedge update), so each byte takes one read cycle plus one write cycle.

Parameters:
- DMA_REG_ADDR, 16'h4014, CPU address that triggers a transfer.
- XFER_LEN, 256, bytes per transfer; fixed, and the index is 8 bits wide.

Ports:
- CLK  in  1  system clock, posedge-sampled logic.
- RESET_n  in  1  asynchronous, active-low reset.
- cpu_address  in  16  CPU bus address.
- cpu_data  in  8  CPU write data.
- cpu_w  in  1  CPU write strobe.
- mem_out  in  8  cpu_memory read data, valid within the current cycle.
- mem_address  out  16  address to cpu_memory (muxed).
- mem_data  out  8  write data to cpu_memory (muxed).
- mem_w  out  1  write enable to cpu_memory (muxed).
- cpu_halt  out  1  stalls the CPU while high.
- dma_busy  out  1  high in any state other than IDLE.
- oam_address  out  8  OAM write index.
- oam_data  out  8  OAM write data.
- oam_w  out  1  OAM write strobe, one cycle.

Behaviour:
- States: IDLE, HALT, ALIGN, READ, WRITE.
- Reset: state=IDLE, page=0, idx=0, byte latch=0, cyc_odd=0. cpu_halt, dma_busy, oam_w, oam_address and oam_data are all 0. Mem outputs pass the CPU through.
- Reset mid-transfer aborts immediately and the CPU is released. No further OAM writes occur.
- cyc_odd toggles on every posedge from reset, regardless of state.
- Bus mux:
  - In IDLE: mem_address/mem_data/mem_w = cpu_address/cpu_data/cpu_w.
  - In any other state: mem_address={page,idx}, mem_data=0, mem_w=0.
- Trigger: at a posedge in IDLE with cpu_w=1 and cpu_address==DMA_REG_ADDR, page<=cpu_data, idx<=0, next state=HALT.
  - The triggering write still passes through to memory that cycle.
- HALT: one dummy cycle, cpu_halt=1.
  - If cyc_odd==1 in HALT, go to READ.
  - Otherwise go to ALIGN (one extra dummy cycle), then READ.
  - Result: READ always starts on an even cycle.
- READ: mem_address={page,idx}. At the posedge, latch mem_out into the byte latch and go to WRITE.
- WRITE: oam_w=1, oam_address=idx, oam_data=latched byte.
  - At the posedge: if idx==8'hFF go to IDLE, else idx<=idx+1 and go to READ.
- cpu_halt and dma_busy are high from the cycle after the trigger through the final WRITE. Both drop in the first IDLE cycle.
- Busy length is 513 cycles without ALIGN, 514 with ALIGN.
- A $4014 write while busy is ignored (the CPU is halted, but the rule is defined anyway).
- idx wraps 8'hFF→8'h00 only at the transfer end. The page is not incremented.
- Pages 00–1F are mirrored inside cpu_memory. This block does no mirroring.
- All outputs are combinational decodes of registered state, with no extra latency.

Optional Feature:
- Macro: OAM_DMA_ALIGN_EN.
- Defined: parity alignment as above, giving 513/514-cycle transfers.
- Undefined: ALIGN is unreachable and HALT always goes to READ. Every transfer is 513 cycles. cyc_odd may be removed.

Decomposition:
- Package nes_bus_pkg holds:
  - typedef enum logic [2:0] dma_state_t {IDLE, HALT, ALIGN, READ, WRITE}
  - localparam OAM_DMA_REG = 16'h4014
  - localparam OAM_DMA_LEN = 256
- Single module; no sub-module is warranted. The bus mux stays inline.

Test Plan:
- Reset with RESET_n=0 asserted mid-cycle → all outputs 0 and mem passes CPU through; release → still IDLE.
- Preload $0200+i = i^8'h5A. Write 8'h02 to $4014 with cyc_odd=1 at HALT → 513 busy cycles, 256 oam_w pulses, each oam_data == addr^8'h5A, oam_address 0..255 in order.
- Same transfer with cyc_odd=0 at HALT, macro defined → exactly one ALIGN cycle, 514 busy cycles. Macro undefined → 513.
- During the transfer, CPU drives cpu_w=1, cpu_address=$0300, cpu_data=8'hAA → mem_w stays 0 and $0300 is unchanged. A $4014 write mid-transfer is ignored.
- Pulse RESET_n low at the 100th WRITE → oam_w stops immediately, cpu_halt=0, and a new $4014 write restarts from idx 0.
- Write 8'h08 to $4014 → read addresses run $0800–$08FF, and the data equals the mirrored $0000–$00FF content.

Source files
------------

// File: rtl/nes_bus_pkg.sv
// Shared NES CPU-bus definitions for the sprite DMA block.
// Contents: DMA FSM state encoding, trigger register address, transfer length.
package nes_bus_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4
    } dma_state_t;

    localparam logic [15:0] OAM_DMA_REG = 16'h4014;
    localparam int unsigned OAM_DMA_LEN = 256;

endpackage

// File: rtl/oam_dma_controller_if.sv
// CPU / cpu_memory / OAM signal bundle around the sprite DMA controller.
// slave  : DMA side (takes CPU request and memory read data, drives mux and OAM port)
// master : environment side (CPU core, cpu_memory, PPU OAM)
interface oam_dma_controller_if;
    logic [15:0] cpu_address;
    logic [7:0]  cpu_data;
    logic        cpu_w;
    logic [7:0]  mem_out;
    logic [15:0] mem_address;
    logic [7:0]  mem_data;
    logic        mem_w;
    logic        cpu_halt;
    logic        dma_busy;
    logic [7:0]  oam_address;
    logic [7:0]  oam_data;
    logic        oam_w;

    modport slave (
        input  cpu_address, cpu_data, cpu_w, mem_out,
        output mem_address, mem_data, mem_w, cpu_halt, dma_busy,
               oam_address, oam_data, oam_w
    );

    modport master (
        output cpu_address, cpu_data, cpu_w, mem_out,
        input  mem_address, mem_data, mem_w, cpu_halt, dma_busy,
               oam_address, oam_data, oam_w
    );
endinterface

// File: rtl/oam_dma_controller.sv
// NES sprite DMA ($4014): halts the CPU, muxes the cpu_memory port and copies
// page $P00-$PFF into PPU OAM, one read cycle plus one write cycle per byte.
// Ports: CLK, RESET_n (async active-low), bus (oam_dma_controller_if.slave).
// Build option: OAM_DMA_ALIGN_EN adds the parity ALIGN cycle so READ starts on
// an even cycle; without it every transfer is 513 cycles.
module oam_dma_controller
    import nes_bus_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RESET_n,
    oam_dma_controller_if.slave   bus
);

    localparam logic [2:0] ST_IDLE  = IDLE;
    localparam logic [2:0] ST_HALT  = HALT;
    localparam logic [2:0] ST_ALIGN = ALIGN;
    localparam logic [2:0] ST_READ  = READ;
    localparam logic [2:0] ST_WRITE = WRITE;

    localparam logic [7:0] LAST_IDX = 8'(OAM_DMA_LEN - 1);

    logic [2:0] r_state;
    logic [2:0] w_next;
    logic [7:0] r_page;
    logic [7:0] r_idx;
    logic [7:0] r_byte;
    logic       w_idle;
    logic       w_trigger;

    assign w_idle    = (r_state == ST_IDLE);
    assign w_trigger = w_idle && bus.cpu_w && (bus.cpu_address == OAM_DMA_REG);

`ifdef OAM_DMA_ALIGN_EN
    logic r_cyc_odd;

    // Free-running cycle parity, used only to align the first READ.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) r_cyc_odd <= 1'b0;
        else          r_cyc_odd <= ~r_cyc_odd;
    end
`endif

    // State register.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_trigger) w_next = ST_HALT;
`ifdef OAM_DMA_ALIGN_EN
            ST_HALT:  w_next = r_cyc_odd ? ST_READ : ST_ALIGN;
`else
            ST_HALT:  w_next = ST_READ;
`endif
            ST_ALIGN: w_next = ST_READ;
            ST_READ:  w_next = ST_WRITE;
            ST_WRITE: w_next = (r_idx == LAST_IDX) ? ST_IDLE : ST_READ;
            default:  w_next = ST_IDLE;
        endcase
    end

    // Page, index and byte latch; idx wraps to 0 on the final WRITE.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            r_page <= 8'd0;
            r_idx  <= 8'd0;
            r_byte <= 8'd0;
        end else begin
            if (w_trigger) begin
                r_page <= bus.cpu_data;
                r_idx  <= 8'd0;
            end
            if (r_state == ST_READ)  r_byte <= bus.mem_out;
            if (r_state == ST_WRITE) r_idx  <= r_idx + 8'd1;
        end
    end

    // Bus mux: CPU passes through only in IDLE (including the trigger write).
    assign bus.mem_address = w_idle ? bus.cpu_address : {r_page, r_idx};
    assign bus.mem_data    = w_idle ? bus.cpu_data    : 8'd0;
    assign bus.mem_w       = w_idle ? bus.cpu_w       : 1'b0;

    assign bus.cpu_halt    = ~w_idle;
    assign bus.dma_busy    = ~w_idle;

    assign bus.oam_w       = (r_state == ST_WRITE);
    assign bus.oam_address = bus.oam_w ? r_idx  : 8'd0;
    assign bus.oam_data    = bus.oam_w ? r_byte : 8'd0;

endmodule

// File: tb/tb_oam_dma_controller.sv
// Bench for oam_dma_controller: cpu_memory model with $0000-$1FFF mirroring,
// reference of each transfer taken from a memory snapshot at the trigger.
module tb_oam_dma_controller;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    bit   tb_par;

    logic [7:0] mem   [0:65535];
    logic [7:0] exp_q [0:255];

    oam_dma_controller_if bus ();

    oam_dma_controller dut (
        .CLK     (clk),
        .RESET_n (rst_n),
        .bus     (bus)
    );

    function automatic logic [15:0] mir(input logic [15:0] a);
        return (a < 16'h2000) ? {5'd0, a[10:0]} : a;
    endfunction

    assign bus.mem_out = mem[mir(bus.mem_address)];

    always @(posedge clk) begin
        if (bus.mem_w === 1'b1) mem[mir(bus.mem_address)] <= bus.mem_data;
    end

    // Cycle parity as seen by the design: cleared by reset, flips every edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_par <= 1'b0;
        else        tb_par <= ~tb_par;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cpu_idle();
        bus.cpu_w       = 1'b0;
        bus.cpu_address = 16'h0000;
        bus.cpu_data    = 8'h00;
    endtask

    // One full transfer; halt_odd picks cyc_odd in HALT, abort_at>0 resets
    // during that WRITE (1-based), poke drives CPU writes while halted.
    task automatic run_xfer(input logic [7:0] page, input bit halt_odd,
                            input int abort_at, input bit poke);
        int busy;
        int nw;
        int exp_busy;
        logic [7:0] snap300;
        logic [7:0] snap4014;
        logic [15:0] a;

        while (tb_par != !halt_odd) step();
        for (int i = 0; i < 256; i++) begin
            a = {page, 8'(i)};
            exp_q[i] = mem[mir(a)];
        end
        snap300 = mem[16'h0300];

        bus.cpu_w       = 1'b1;
        bus.cpu_address = 16'h4014;
        bus.cpu_data    = page;
        #1;
        chk("trig_pass_addr", 32'(bus.mem_address), 32'h4014);
        chk("trig_pass_w",    32'(bus.mem_w), 32'd1);
        chk("trig_pass_data", 32'(bus.mem_data), 32'(page));
        step();
        cpu_idle();
        chk("trig_mem_write", 32'(mem[16'h4014]), 32'(page));
        snap4014 = page;

`ifdef OAM_DMA_ALIGN_EN
        exp_busy = halt_odd ? 513 : 514;
`else
        exp_busy = 513;
`endif
        busy = 0;
        nw   = 0;
        while (bus.dma_busy === 1'b1 && busy < 700) begin
            busy++;
            chk("halt_hi",   32'(bus.cpu_halt), 32'd1);
            chk("mem_w_blk", 32'(bus.mem_w), 32'd0);
            chk("dma_addr",  32'(bus.mem_address), 32'({page, 8'(nw)}));
            if (bus.oam_w === 1'b1) begin
                chk("oam_addr", 32'(bus.oam_address), 32'(nw));
                chk("oam_data", 32'(bus.oam_data), 32'(exp_q[nw[7:0]]));
                nw++;
                if (nw == abort_at) begin
                    rst_n = 1'b0;
                    #1;
                    chk("abort_oam_w", 32'(bus.oam_w), 32'd0);
                    chk("abort_halt",  32'(bus.cpu_halt), 32'd0);
                    chk("abort_busy",  32'(bus.dma_busy), 32'd0);
                    chk("abort_pass",  32'(bus.mem_address), 32'(bus.cpu_address));
                    @(negedge clk);
                    rst_n = 1'b1;
                    for (int k = 0; k < 3; k++) begin
                        step();
                        chk("abort_no_oam", 32'(bus.oam_w), 32'd0);
                    end
                    return;
                end
            end
            if (poke && busy >= 100 && busy < 110) begin
                bus.cpu_w = 1'b1; bus.cpu_address = 16'h4014; bus.cpu_data = 8'h55;
            end else if (poke && busy >= 200 && busy < 210) begin
                bus.cpu_w = 1'b1; bus.cpu_address = 16'h0300; bus.cpu_data = 8'hAA;
            end else begin
                cpu_idle();
            end
            step();
        end
        chk("busy_len",   32'(busy), 32'(exp_busy));
        chk("oam_count",  32'(nw), 32'd256);
        chk("end_idle",   32'(bus.dma_busy), 32'd0);
        chk("end_halt",   32'(bus.cpu_halt), 32'd0);
        chk("end_pass",   32'(bus.mem_address), 32'(bus.cpu_address));
        chk("mem300_kept",  32'(mem[16'h0300]), 32'(snap300));
        chk("mem4014_kept", 32'(mem[16'h4014]), 32'(snap4014));
    endtask

    initial begin
        logic [7:0] rp;
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        bus.cpu_w       = 1'b0;
        bus.cpu_address = 16'(($urandom % 16'h3FFF) + 1);
        bus.cpu_data    = 8'($urandom);

        for (int i = 0; i < 65536; i++) mem[i] <= 8'($urandom);
        for (int i = 0; i < 256; i++)   mem[16'h0200 + i] <= 8'(i) ^ 8'h5A;
        mem[16'h0300] <= 8'h3C;

        step(); step();
        chk("rst_halt", 32'(bus.cpu_halt), 32'd0);
        chk("rst_busy", 32'(bus.dma_busy), 32'd0);
        chk("rst_oam_w", 32'(bus.oam_w), 32'd0);
        chk("rst_oam_a", 32'(bus.oam_address), 32'd0);
        chk("rst_oam_d", 32'(bus.oam_data), 32'd0);
        chk("rst_pass_a", 32'(bus.mem_address), 32'(bus.cpu_address));
        chk("rst_pass_d", 32'(bus.mem_data), 32'(bus.cpu_data));
        @(negedge clk);
        rst_n = 1'b1;
        step(); step();
        chk("post_rst_busy", 32'(bus.dma_busy), 32'd0);
        bus.cpu_w = 1'b1;
        #1;
        chk("post_rst_pass_w", 32'(bus.mem_w), 32'd1);
        cpu_idle();
        step();
        // Mid-cycle reset while idle.
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(bus.dma_busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        run_xfer(8'h02, 1'b1, 0, 1'b1);
        run_xfer(8'h02, 1'b0, 0, 1'b0);
        run_xfer(8'h02, 1'b1, 100, 1'b0);
        run_xfer(8'h02, 1'b0, 0, 1'b0);
        run_xfer(8'h08, 1'($urandom), 0, 1'b0);
        rp = 8'($urandom_range(32'h20, 32'hFF));
        if (rp == 8'h40) rp = 8'h41;
        run_xfer(rp, 1'($urandom), 0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
